// File: rtl/dcache_miss_handler_pkg.sv
// Shared types and address-field widths for the data-cache load-miss handler.
package dcache_miss_handler_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BLOCK_WORDS = 4;
    localparam int unsigned SETS        = 64;

    localparam int unsigned BYTE_W   = 2;
    localparam int unsigned OFFSET_W = $clog2(BLOCK_WORDS);
    localparam int unsigned INDEX_W  = $clog2(SETS);
    localparam int unsigned LINE_LSB = OFFSET_W + BYTE_W;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W - BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        REQ,
        FILL,
        DONE
    } dmiss_state_t;

    typedef struct packed {
        logic                we;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] word;
        logic [DATA_W-1:0]   data;
    } dcache_fill_t;

endpackage

// File: rtl/dcache_line_addr.sv
// Splits a byte address into tag / set index / in-line byte offset and the line-aligned address.
module dcache_line_addr
    import dcache_miss_handler_pkg::*;
(
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [TAG_W-1:0]    o_tag,
    output logic [INDEX_W-1:0]  o_index,
    output logic [LINE_LSB-1:0] o_offset,
    output logic [ADDR_W-1:0]   o_line_addr
);

    assign o_tag       = i_addr[ADDR_W-1 -: TAG_W];
    assign o_index     = i_addr[LINE_LSB +: INDEX_W];
    assign o_offset    = i_addr[LINE_LSB-1:0];
    assign o_line_addr = {i_addr[ADDR_W-1:LINE_LSB], LINE_LSB'(0)};

endmodule

// File: rtl/dcache_miss_handler.sv
// Load-miss controller: accepts a miss, issues a line burst read and writes the beats into the cache arrays.
module dcache_miss_handler
    import dcache_miss_handler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                lookup_hit,
    input  logic                flush,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                fill_we,
    output logic [INDEX_W-1:0]  fill_index,
    output logic [OFFSET_W-1:0] fill_word,
    output logic [DATA_W-1:0]   fill_data,
    output logic                tag_we,
    output logic [TAG_W-1:0]    fill_tag,
    output logic                data_missed1,
    output logic                data_busy,
    output logic                data_finished1
);

    localparam logic [OFFSET_W-1:0] BEAT_LAST = OFFSET_W'(BLOCK_WORDS - 1);

    dmiss_state_t        r_state;
    dmiss_state_t        w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [OFFSET_W-1:0] r_beat;
    logic                r_drop;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    dcache_fill_t        r_fill;
    logic                r_tag_we;
    logic [TAG_W-1:0]    r_fill_tag;
    logic                r_data_missed1;
    logic                r_data_busy;
    logic                r_data_finished1;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [LINE_LSB-1:0] w_unused_offset;
    logic [ADDR_W-1:0]   w_line_addr;
    logic                w_beat_fire;
    logic                w_last_beat;
    logic                w_drop;

    dcache_line_addr u_line_addr (
        .i_addr      (r_addr),
        .o_tag       (w_tag),
        .o_index     (w_index),
        .o_offset    (w_unused_offset),
        .o_line_addr (w_line_addr)
    );

    assign w_beat_fire = (r_state == FILL) && mem_rvalid;
    assign w_last_beat = (r_beat == BEAT_LAST);
    // A flush arriving on a beat cycle already suppresses that beat.
    assign w_drop      = r_drop || flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (req_valid && !lookup_hit && !flush) w_next = MISS;
            MISS: w_next = flush ? IDLE : REQ;
            // Once memory has taken the request the burst must be drained, even under flush.
            REQ: begin
                if (r_mem_req && mem_ready) w_next = FILL;
                else if (flush)             w_next = IDLE;
            end
            FILL: if (w_beat_fire && w_last_beat) w_next = w_drop ? IDLE : DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs track the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr           <= '0;
            r_beat           <= '0;
            r_drop           <= 1'b0;
            r_mem_req        <= 1'b0;
            r_mem_addr       <= '0;
            r_fill           <= '0;
            r_tag_we         <= 1'b0;
            r_fill_tag       <= '0;
            r_data_missed1   <= 1'b0;
            r_data_busy      <= 1'b0;
            r_data_finished1 <= 1'b0;
        end else begin
            r_data_missed1   <= (w_next == MISS);
            r_mem_req        <= (w_next == REQ);
            r_data_busy      <= (w_next == REQ) || (w_next == FILL);
            r_data_finished1 <= (w_next == DONE);
            r_fill.we        <= w_beat_fire && !w_drop;
            r_tag_we         <= w_beat_fire && !w_drop && w_last_beat;

            if (r_state == IDLE && w_next == MISS) r_addr <= req_addr;
            if (r_state == MISS && w_next == REQ)  r_mem_addr <= w_line_addr;

            if (r_state == REQ && w_next == FILL) begin
                r_beat <= '0;
                r_drop <= flush;
            end else if (r_state != FILL) begin
                r_drop <= 1'b0;
            end else if (flush) begin
                r_drop <= 1'b1;
            end

            if (w_beat_fire) begin
                r_fill.index <= w_index;
                r_fill.word  <= r_beat;
                r_fill.data  <= mem_rdata;
                r_beat       <= r_beat + OFFSET_W'(1);
            end
            if (w_beat_fire && w_last_beat && !w_drop) r_fill_tag <= w_tag;
        end
    end

    assign mem_req        = r_mem_req;
    assign mem_addr       = r_mem_addr;
    assign fill_we        = r_fill.we;
    assign fill_index     = r_fill.index;
    assign fill_word      = r_fill.word;
    assign fill_data      = r_fill.data;
    assign tag_we         = r_tag_we;
    assign fill_tag       = r_fill_tag;
    assign data_missed1   = r_data_missed1;
    assign data_busy      = r_data_busy;
    assign data_finished1 = r_data_finished1;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Directed-vector bench for dcache_miss_handler; inputs change and outputs are sampled on the falling edge.
module tb_dcache_miss_handler;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        lookup_hit;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        fill_we;
    logic [5:0]  fill_index;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic        tag_we;
    logic [21:0] fill_tag;
    logic        data_missed1;
    logic        data_busy;
    logic        data_finished1;

    int n_vec;
    int n_err;

    dcache_miss_handler dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .lookup_hit     (lookup_hit),
        .flush          (flush),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .fill_we        (fill_we),
        .fill_index     (fill_index),
        .fill_word      (fill_word),
        .fill_data      (fill_data),
        .tag_we         (tag_we),
        .fill_tag       (fill_tag),
        .data_missed1   (data_missed1),
        .data_busy      (data_busy),
        .data_finished1 (data_finished1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept a miss at addr, hold REQ for one cycle, hand-shake on the second; ends in the first FILL cycle.
    task automatic start_miss(input logic [31:0] addr, input logic [31:0] line);
        req_valid = 1'b1; lookup_hit = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0;
        n_vec++; if ({data_missed1, data_busy, mem_req} !== 3'b100) begin
            n_err++; $display("FAIL miss_accept {missed1,busy,req} got=%b exp=100", {data_missed1, data_busy, mem_req});
        end
        tick();
        n_vec++; if ({mem_req, data_busy, data_missed1} !== 3'b110 || mem_addr !== line) begin
            n_err++; $display("FAIL req_enter {req,busy,missed1}=%b addr=%h exp 110 addr=%h", {mem_req, data_busy, data_missed1}, mem_addr, line);
        end
        tick();
        n_vec++; if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL req_hold mem_req got=%b exp=1", mem_req);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        n_vec++; if ({mem_req, data_busy} !== 2'b01) begin
            n_err++; $display("FAIL fill_enter {req,busy} got=%b exp=01", {mem_req, data_busy});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        n_vec++; if ({mem_req, fill_we, tag_we, data_missed1, data_busy, data_finished1} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=000000", {mem_req, fill_we, tag_we, data_missed1, data_busy, data_finished1});
        end
        n_vec++; if ({mem_addr, fill_index, fill_word, fill_data, fill_tag} !== '0) begin
            n_err++; $display("FAIL reset_bus addr=%h idx=%h word=%h data=%h tag=%h exp all 0", mem_addr, fill_index, fill_word, fill_data, fill_tag);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        req_valid = 1'b1; lookup_hit = 1'b1; req_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if ({data_missed1, mem_req, data_busy} !== 3'b000) begin
                n_err++; $display("FAIL hit_cyc%0d {missed1,req,busy} got=%b exp=000", i, {data_missed1, mem_req, data_busy});
            end
        end
        req_valid = 1'b0; lookup_hit = 1'b0;
        // Flush wins over a simultaneous miss.
        req_valid = 1'b1; flush = 1'b1; req_addr = 32'h200;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        n_vec++; if (data_missed1 !== 1'b0) begin
            n_err++; $display("FAIL flush_vs_miss missed1 got=%b exp=0", data_missed1);
        end
        tick();
        n_vec++; if (mem_req !== 1'b0) begin
            n_err++; $display("FAIL flush_vs_miss mem_req got=%b exp=0", mem_req);
        end
    endtask

    task automatic test_clean_miss();
        start_miss(32'h1234, 32'h1230);
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA0 + 32'(i);
            tick();
            n_vec++; if (fill_we !== 1'b1 || fill_word !== 2'(i) || fill_data !== 32'hA0 + 32'(i) || fill_index !== 6'h23) begin
                n_err++; $display("FAIL clean_beat%0d we=%b word=%0d data=%h idx=%h exp 1 %0d %h 23", i, fill_we, fill_word, fill_data, fill_index, i, 32'hA0 + 32'(i));
            end
            n_vec++; if (tag_we !== (i == 3) || data_finished1 !== (i == 3) || data_busy !== (i < 3)) begin
                n_err++; $display("FAIL clean_ctl%0d tag_we=%b fin=%b busy=%b exp %b %b %b", i, tag_we, data_finished1, data_busy, i == 3, i == 3, i < 3);
            end
        end
        mem_rvalid = 1'b0;
        n_vec++; if (fill_tag !== 22'h4) begin
            n_err++; $display("FAIL clean_tag got=%h exp=4", fill_tag);
        end
        tick();
        n_vec++; if ({data_finished1, fill_we, tag_we, data_busy, mem_req} !== 5'b0) begin
            n_err++; $display("FAIL clean_idle {fin,we,tag_we,busy,req} got=%b exp=00000", {data_finished1, fill_we, tag_we, data_busy, mem_req});
        end
    endtask

    task automatic test_gapped_beats();
        logic [6:0] pat;
        int         pulses;
        int         exp_word;
        pat = 7'b1011001;
        pulses = 0; exp_word = 0;
        start_miss(32'h2468, 32'h2460);
        for (int k = 0; k < 7; k++) begin
            mem_rvalid = pat[k]; mem_rdata = 32'hB0 + 32'(exp_word);
            tick();
            n_vec++; if (fill_we !== pat[k] || data_busy !== (k < 6)) begin
                n_err++; $display("FAIL gap_cyc%0d we=%b busy=%b exp %b %b", k, fill_we, data_busy, pat[k], k < 6);
            end
            if (pat[k]) begin
                pulses++;
                n_vec++; if (fill_word !== 2'(exp_word) || fill_data !== 32'hB0 + 32'(exp_word) || fill_index !== 6'h06) begin
                    n_err++; $display("FAIL gap_word word=%0d data=%h idx=%h exp %0d %h 06", fill_word, fill_data, fill_index, exp_word, 32'hB0 + 32'(exp_word));
                end
                exp_word++;
            end else if (fill_we === 1'b1) begin
                pulses++;
            end
        end
        mem_rvalid = 1'b0;
        n_vec++; if (pulses != 4 || tag_we !== 1'b1 || fill_tag !== 22'h9 || data_finished1 !== 1'b1) begin
            n_err++; $display("FAIL gap_end pulses=%0d tag_we=%b tag=%h fin=%b exp 4 1 9 1", pulses, tag_we, fill_tag, data_finished1);
        end
        tick();
    endtask

    task automatic test_flush_req();
        req_valid = 1'b1; lookup_hit = 1'b0; req_addr = 32'h3000;
        tick();
        req_valid = 1'b0;
        tick();
        n_vec++; if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL flreq_req got=%b exp=1", mem_req);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++; if ({mem_req, data_busy} !== 2'b00) begin
            n_err++; $display("FAIL flreq_drop {req,busy} got=%b exp=00", {mem_req, data_busy});
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if ({fill_we, tag_we, data_finished1, mem_req} !== 4'b0) begin
                n_err++; $display("FAIL flreq_quiet%0d {we,tag_we,fin,req} got=%b exp=0000", i, {fill_we, tag_we, data_finished1, mem_req});
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_flush_fill();
        start_miss(32'h4010, 32'h4010);
        mem_rvalid = 1'b1; mem_rdata = 32'hC0;
        tick();
        n_vec++; if (fill_we !== 1'b1 || fill_word !== 2'd0 || fill_data !== 32'hC0) begin
            n_err++; $display("FAIL flfill_beat0 we=%b word=%0d data=%h exp 1 0 c0", fill_we, fill_word, fill_data);
        end
        mem_rvalid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++; if (fill_we !== 1'b0 || data_busy !== 1'b1) begin
            n_err++; $display("FAIL flfill_flush we=%b busy=%b exp 0 1", fill_we, data_busy);
        end
        for (int i = 1; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hC0 + 32'(i);
            tick();
            n_vec++; if ({fill_we, tag_we, data_finished1} !== 3'b000 || data_busy !== (i < 3)) begin
                n_err++; $display("FAIL flfill_beat%0d {we,tag_we,fin}=%b busy=%b exp 000 %b", i, {fill_we, tag_we, data_finished1}, data_busy, i < 3);
            end
        end
        mem_rvalid = 1'b0;
        // Back in IDLE right after the last drained beat: a new miss is accepted immediately.
        req_valid = 1'b1; req_addr = 32'h5000;
        tick();
        req_valid = 1'b0;
        n_vec++; if (data_missed1 !== 1'b1 || data_finished1 !== 1'b0) begin
            n_err++; $display("FAIL flfill_idle missed1=%b fin=%b exp 1 0", data_missed1, data_finished1);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++; if ({mem_req, data_busy, data_missed1} !== 3'b000) begin
            n_err++; $display("FAIL flmiss_abort {req,busy,missed1} got=%b exp=000", {mem_req, data_busy, data_missed1});
        end
    endtask

    task automatic test_reset_mid_fill();
        start_miss(32'h6ABC, 32'h6AB0);
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hE0 + 32'(i);
            tick();
        end
        n_vec++; if (fill_we !== 1'b1 || fill_word !== 2'd2 || fill_index !== 6'h2B) begin
            n_err++; $display("FAIL rstfill_beat2 we=%b word=%0d idx=%h exp 1 2 2b", fill_we, fill_word, fill_index);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_vec++; if ({mem_req, fill_we, tag_we, data_missed1, data_busy, data_finished1} !== 6'b0
                     || {mem_addr, fill_index, fill_word, fill_data, fill_tag} !== '0) begin
            n_err++; $display("FAIL rstfill_clear ctrl=%b addr=%h idx=%h word=%h data=%h tag=%h exp all 0",
                              {mem_req, fill_we, tag_we, data_missed1, data_busy, data_finished1},
                              mem_addr, fill_index, fill_word, fill_data, fill_tag);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if ({fill_we, tag_we, data_busy, data_finished1} !== 4'b0) begin
                n_err++; $display("FAIL rstfill_stray%0d {we,tag_we,busy,fin} got=%b exp=0000", i, {fill_we, tag_we, data_busy, data_finished1});
            end
        end
        mem_rvalid = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; lookup_hit = 1'b0; flush = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_hit();
        test_clean_miss();
        test_gapped_beats();
        test_flush_req();
        test_flush_fill();
        test_reset_mid_fill();
        test_clean_miss();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_miss_handler.md
Name: dcache_miss_handler

Overview:
- Load-miss controller for the data cache. Sits between the MEM stage tag lookup and the external memory bus.
- On a load miss it fetches the whole line as a burst and writes it into the external data/tag arrays.
- Drives data_missed1, data_busy and data_finished1, which hazard_detection consumes to raise backend_stall.
- Stores and write-buffer traffic are out of scope.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, bus/word width in bits.
- BLOCK_WORDS, 4, words per cache line; power of 2, at least 2.
- SETS, 64, cache sets; power of 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous active-low reset (0 = reset).
- req_valid  in  1  MEM stage presents a load this cycle (mem_read).
- req_addr  in  ADDR_W  load byte address.
- lookup_hit  in  1  tag compare result for req_addr; valid with req_valid.
- flush  in  1  pipeline flush; abandons the miss in progress.
- mem_req  out  1  burst read request to memory.
- mem_addr  out  ADDR_W  line-aligned burst address.
- mem_ready  in  1  memory accepts the request (handshake with mem_req).
- mem_rvalid  in  1  one burst beat present on mem_rdata.
- mem_rdata  in  DATA_W  beat data.
- fill_we  out  1  write one word into the data array.
- fill_index  out  log2(SETS)  set index for the fill.
- fill_word  out  log2(BLOCK_WORDS)  word offset within the line.
- fill_data  out  DATA_W  word to write.
- tag_we  out  1  write tag and set the valid bit for fill_index.
- fill_tag  out  ADDR_W-log2(SETS)-log2(BLOCK_WORDS)-2  tag to write.
- data_missed1  out  1  one-cycle pulse: a miss was accepted.
- data_busy  out  1  refill in progress.
- data_finished1  out  1  one-cycle pulse: line installed; the retried load will hit.

Behaviour:
- States: IDLE, MISS, REQ, FILL, DONE. All outputs are registered.
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - mem_req, fill_we, tag_we, data_missed1, data_busy, data_finished1 all go to 0.
  - Beat counter, drop flag, latched address and fill_* buses go to 0.
  - Reset during any state aborts immediately; later memory beats are ignored.
- IDLE:
  - If req_valid && !lookup_hit && !flush: latch req_addr, go to MISS.
  - A hit or no request stays in IDLE.
- MISS:
  - data_missed1=1 for exactly this cycle; data_busy=0.
  - Next state is REQ, or IDLE if flush.
  - Latency: miss seen at cycle t gives data_missed1 at t+1.
- REQ:
  - mem_req=1, data_busy=1, mem_addr = latched address with the low log2(BLOCK_WORDS)+2 bits zeroed.
  - Hold until mem_req && mem_ready; then go to FILL with beat counter 0.
  - flush before the handshake: drop mem_req and go to IDLE.
- FILL:
  - data_busy=1. Each mem_rvalid beat:
    - fill_we=1, fill_word=counter, fill_data=mem_rdata, fill_index from the latched address.
    - Counter increments.
  - Cycles without mem_rvalid: fill_we=0, counter holds.
  - On beat BLOCK_WORDS-1: tag_we=1 with fill_tag, then go to DONE. The counter wraps to 0.
  - flush during FILL sets the drop flag. Remaining beats are still consumed but fill_we and tag_we are suppressed. After the last beat go to IDLE, skipping DONE.
- DONE:
  - data_finished1=1 for one cycle, data_busy=0, then IDLE.
  - A req_valid arriving in DONE is ignored. The stalled load re-presents in IDLE and hits.
- req_valid in MISS, REQ or FILL is ignored; the requester is held by backend_stall.
- mem_rvalid outside FILL is ignored.
- flush and a miss in the same IDLE cycle: flush wins, no miss is accepted.

Decomposition:
- Shared package holds:
  - the dmiss_state_t enum (IDLE, MISS, REQ, FILL, DONE);
  - localparams for OFFSET_W, INDEX_W, TAG_W, derived from the parameters;
  - a dcache_fill_t struct bundling the fill_* fields.
- One natural sub-module, dcache_line_addr: pure address split producing tag, index, offset and the line-aligned address. Reused by the tag lookup.

Test Plan:
- Hit: req_valid=1, lookup_hit=1, addr 0x100 → no data_missed1, mem_req stays 0, state stays IDLE.
- Clean miss:
  - Stimulus: addr 0x1234, mem_ready on the 2nd REQ cycle, 4 back-to-back beats 0xA0..0xA3.
  - Required: data_missed1 at t+1; mem_addr=0x1230; fill_index=0x23; fill_word 0..3 with matching data; tag_we on the 4th beat; data_finished1 exactly one cycle later.
- Gapped beats: mem_rvalid pattern 1,0,0,1,1,0,1 → exactly 4 fill_we pulses, fill_word 0,1,2,3, data_busy held through the gaps.
- Flush in REQ: flush asserted before mem_ready → mem_req falls next cycle, IDLE, no fill_we, no data_finished1.
- Flush in FILL: flush after beat 1 → beat 0 written; beats 1..3 consumed with no fill_we; no tag_we, no data_finished1; back in IDLE after beat 3.
- Reset mid-FILL: reset=0 after beat 2 → all outputs 0 next cycle; later mem_rvalid pulses produce no fill_we; a new miss afterwards behaves as in the clean-miss case.
